// File: rtl/pll_ctrl_seq.sv
// PLL control sequencer: timed PLL reset, synchronized lock qualification, glitch-safe
// clock-select switching, lock-loss restart and retry/fault supervision.
// Define PLL_CTRL_LOCK_LOSS_CNT_EN to build the saturating lock-loss event counter.
module pll_ctrl_seq #(
  parameter int RST_CYCLES    = 50,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel_in,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic [1:0] pll_sel,
  output logic       clk_ready,
  output logic       busy,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES + 1) ? RST_CYCLES : SETTLE_CYCLES + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST  = CW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_SETTLE,
    S_READY,
    S_SWITCH,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    retry_q, retry_d;
  logic [1:0]    sel_pend_q, sel_pend_d;
  logic [1:0]    pll_sel_q, pll_sel_d;
  logic          sync_q, lk_s_q;
  logic          pll_rst_q, clk_ready_q, busy_q, fault_q;
  logic          attempt_fail;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    retry_d      = retry_q;
    sel_pend_d   = sel_pend_q;
    pll_sel_d    = pll_sel_q;
    attempt_fail = 1'b0;

    case (state_q)
      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          tcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (tcnt_q != TMO_LAST) tcnt_d = tcnt_q + 1'b1;
        // The cycle that sees lock counts as the first settle cycle.
        if (lk_s_q) begin
          state_d = S_SETTLE;
          cnt_d   = CW'(1);
        end else if (tcnt_q == TMO_LAST) begin
          attempt_fail = 1'b1;
        end
      end
      S_SETTLE: begin
        if (tcnt_q != TMO_LAST) tcnt_d = tcnt_q + 1'b1;
        if (!lk_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q >= SETTLE_LAST) begin
          state_d = S_READY;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READY: begin
        if (!lk_s_q) begin
          state_d = S_RESET;
          cnt_d   = '0;
        end else if (sel_in != pll_sel_q) begin
          state_d    = S_SWITCH;
          sel_pend_d = sel_in;
          cnt_d      = '0;
        end
      end
      S_SWITCH: begin
        if (!lk_s_q) begin
          state_d = S_RESET;
          cnt_d   = '0;
        end else begin
          // clk_ready is already low here, so the select can move safely.
          if (cnt_q == '0) pll_sel_d = sel_pend_q;
          if (cnt_q == BLANK_LAST) state_d = S_READY;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      S_FAULT: ;
      default: state_d = S_RESET;
    endcase

    if (attempt_fail) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = S_RESET;
        cnt_d   = '0;
      end else begin
        state_d = S_FAULT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 1'b0;
      lk_s_q      <= 1'b0;
      state_q     <= S_RESET;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      retry_q     <= '0;
      sel_pend_q  <= '0;
      pll_sel_q   <= '0;
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      sync_q      <= pll_locked;
      lk_s_q      <= sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      retry_q     <= retry_d;
      sel_pend_q  <= sel_pend_d;
      pll_sel_q   <= pll_sel_d;
      pll_rst_q   <= (state_d == S_RESET) || (state_d == S_FAULT);
      clk_ready_q <= (state_d == S_READY);
      busy_q      <= (state_d != S_READY) && (state_d != S_FAULT);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign pll_sel   = pll_sel_q;
  assign clk_ready = clk_ready_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

`ifdef PLL_CTRL_LOCK_LOSS_CNT_EN
  logic       lock_loss;
  logic [7:0] lcnt_q;

  assign lock_loss = ((state_q == S_READY) || (state_q == S_SWITCH)) && !lk_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt_q <= 8'h00;
    end else if (lock_loss && (lcnt_q != 8'hFF)) begin
      lcnt_q <= lcnt_q + 8'h01;
    end
  end

  assign lock_loss_cnt = lcnt_q;
`else
  assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_ctrl_seq.sv
// Directed-sequence bench for pll_ctrl_seq with randomized delays and selects; expected
// outputs come from event timing derived arithmetically from the sequencing rules.
module tb_pll_ctrl_seq;

  logic       clk;
  logic       rst;
  logic [1:0] sel_in;
  logic       pll_locked;
  logic       pll_rst;
  logic [1:0] pll_sel;
  logic       clk_ready;
  logic       busy;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int         total;
  int         bad;
  int         exp_ll;
  logic [1:0] cur_sel;

  pll_ctrl_seq dut (
    .clk           (clk),
    .rst           (rst),
    .sel_in        (sel_in),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .pll_sel       (pll_sel),
    .clk_ready     (clk_ready),
    .busy          (busy),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_lcnt();
`ifdef PLL_CTRL_LOCK_LOSS_CNT_EN
    return (exp_ll > 255) ? 8'hFF : 8'(exp_ll);
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk_out(input string tag, input logic e_rst, input logic [1:0] e_sel,
                         input logic e_rdy, input logic e_busy, input logic e_fault,
                         input logic [1:0] e_retry);
    chk({tag, ".pll_rst"}, pll_rst, e_rst);
    chk({tag, ".pll_sel"}, pll_sel, e_sel);
    chk({tag, ".clk_ready"}, clk_ready, e_rdy);
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".fault"}, fault, e_fault);
    chk({tag, ".retry_cnt"}, retry_cnt, e_retry);
    chk({tag, ".lock_loss_cnt"}, lock_loss_cnt, exp_lcnt());
  endtask

  function automatic logic [1:0] pick_sel(input logic [1:0] avoid);
    logic [1:0] s;
    s = 2'($urandom_range(0, 3));
    if (s == avoid) s = s + 2'd1;
    return s;
  endfunction

  // Release reset, lock d cycles into WAIT_LOCK, expect READY 18 edges after lock rises.
  task automatic boot(input string tag, input int d);
    rst = 1'b0;
    for (int n = 1; n <= 50 + d; n++) begin
      step();
      chk_out(tag, n < 50, cur_sel, 1'b0, 1'b1, 1'b0, 2'd0);
    end
    pll_locked = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      step();
      chk_out(tag, 1'b0, cur_sel, n >= 18, n < 18, 1'b0, 2'd0);
    end
  endtask

  task automatic idle(input string tag, input int k);
    for (int n = 0; n < k; n++) begin
      step();
      chk_out(tag, 1'b0, cur_sel, 1'b1, 1'b0, 1'b0, 2'd0);
    end
  endtask

  // Select lands one edge after the request; clk_ready is low for 17 edges.
  task automatic switch_to(input string tag, input logic [1:0] s);
    logic [1:0] old;
    old    = cur_sel;
    sel_in = s;
    for (int n = 1; n <= 18; n++) begin
      step();
      chk_out(tag, 1'b0, (n >= 2) ? s : old, n >= 18, n < 18, 1'b0, 2'd0);
    end
    cur_sel = s;
    idle({tag, ".idle"}, $urandom_range(20, 500));
  endtask

  initial begin
    int         d;
    int         rdy_n;
    int         g;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] old;

    total      = 0;
    bad        = 0;
    exp_ll     = 0;
    cur_sel    = 2'b00;
    rst        = 1'b1;
    sel_in     = 2'b00;
    pll_locked = 1'b0;

    #20;
    chk_out("reset", 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0);
    #480;
    boot("boot", $urandom_range(5, 600));

    switch_to("sw_01", 2'b01);
    switch_to("sw_10", 2'b10);
    switch_to("sw_11", 2'b11);
    for (int i = 0; i < 3; i++) switch_to("sw_rand", pick_sel(cur_sel));

    // sel_in moves during blanking: ignored, then picked up on return to READY
    old    = cur_sel;
    s1     = pick_sel(old);
    s2     = pick_sel(s1);
    sel_in = s1;
    for (int n = 1; n <= 36; n++) begin
      step();
      chk_out("sw_blank", 1'b0, (n < 2) ? old : ((n < 20) ? s1 : s2),
              (n == 18) || (n >= 36), !((n == 18) || (n >= 36)), 1'b0, 2'd0);
      if (n == 5) sel_in = s2;
    end
    cur_sel = s2;
    idle("sw_blank.idle", 30);

    // lock loss in READY, relock after d cycles
    d          = $urandom_range(10, 200);
    rdy_n      = ((d + 3 > 54) ? d + 3 : 54) + 15;
    pll_locked = 1'b0;
    for (int n = 1; n <= rdy_n + 5; n++) begin
      step();
      if (n == 3) exp_ll++;
      chk_out("loss_ready", (n >= 3) && (n < 53), cur_sel, (n < 3) || (n >= rdy_n),
              !((n < 3) || (n >= rdy_n)), 1'b0, 2'd0);
      if (n == d) pll_locked = 1'b1;
    end

    // lock loss during SWITCH, after the select has been applied
    old    = cur_sel;
    s1     = pick_sel(old);
    sel_in = s1;
    d      = $urandom_range(10, 100);
    rdy_n  = ((d + 3 > 57) ? d + 3 : 57) + 15;
    for (int n = 1; n <= rdy_n + 5; n++) begin
      step();
      if (n == 6) exp_ll++;
      chk_out("loss_switch", (n >= 6) && (n < 56), (n < 2) ? old : s1, n >= rdy_n,
              n < rdy_n, 1'b0, 2'd0);
      if (n == 3) pll_locked = 1'b0;
      if (n == d) pll_locked = 1'b1;
    end
    cur_sel = s1;
    idle("loss_switch.idle", 20);

    // lock lost for good: four 1050-cycle attempts, then FAULT
    pll_locked = 1'b0;
    for (int n = 1; n <= 4215; n++) begin
      int m;
      int k;
      step();
      if (n == 3) exp_ll++;
      m = n - 3;
      k = (m >= 0) ? m / 1050 : 0;
      if (n < 3)
        chk_out("timeout", 1'b0, cur_sel, 1'b1, 1'b0, 1'b0, 2'd0);
      else if (k >= 4)
        chk_out("timeout", 1'b1, cur_sel, 1'b0, 1'b0, 1'b1, 2'd3);
      else
        chk_out("timeout", (m % 1050) < 50, cur_sel, 1'b0, 1'b1, 1'b0, 2'(k));
    end

    rst     = 1'b1;
    exp_ll  = 0;
    cur_sel = 2'b00;
    #1;
    chk_out("rst_clears_fault", 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0);

    // a 5-cycle lock glitch must not qualify nor restart the timeout
    #1;
    rst = 1'b0;
    g   = $urandom_range(60, 900);
    for (int n = 1; n <= 1060; n++) begin
      step();
      chk_out("glitch", (n < 50) || (n >= 1050), 2'b00, 1'b0, 1'b1, 1'b0,
              (n >= 1050) ? 2'd1 : 2'd0);
      if (n == g) pll_locked = 1'b1;
      if (n == g + 5) pll_locked = 1'b0;
    end

    // asynchronous reset between edges in the middle of a switch
    rst = 1'b1;
    #2;
    boot("reboot", $urandom_range(5, 300));
    s1     = pick_sel(2'b00);
    sel_in = s1;
    for (int n = 1; n <= 3; n++) begin
      step();
      chk_out("pre_async", 1'b0, (n >= 2) ? s1 : 2'b00, 1'b0, 1'b1, 1'b0, 2'd0);
    end
    #3;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
